// File: rtl/lcd_hd44780_sequencer.sv
// HD44780 write-cycle sequencer: turns PIO go-toggle words into timed RS/DATA/EN
// cycles with a one-deep pending buffer and a sticky overflow flag.
module lcd_hd44780_sequencer #(
    parameter int T_AS    = 3,
    parameter int T_PW    = 12,
    parameter int T_H     = 2,
    parameter int T_SHORT = 2000,
    parameter int T_LONG  = 82000,
    parameter int CW      = 17
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] in_port,
    input  logic        ovf_clr,
    output logic        busy,
    output logic        overflow,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic        lcd_on,
    output logic        lcd_blon
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic          go_prev;
    logic          pend_valid;
    logic          pend_rs;
    logic [7:0]    pend_data;
    logic          go;
    logic          consume;
    logic          ovf_set;

    // Clear display (0x01) and return home (0x02/0x03) need the long settle time.
    function automatic logic [CW-1:0] wait_load(input logic rs, input logic [7:0] data);
        if (!rs && (data == 8'h01 || data == 8'h02 || data == 8'h03))
            return CW'(T_LONG - 1);
        return CW'(T_SHORT - 1);
    endfunction

    assign go       = in_port[11] ^ go_prev;
    assign consume  = (state == S_IDLE) && pend_valid;
    assign ovf_set  = go && pend_valid && !consume;
    assign busy     = (state != S_IDLE) || pend_valid;
    assign lcd_rw   = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            go_prev    <= 1'b0;
            pend_valid <= 1'b0;
            pend_rs    <= 1'b0;
            pend_data  <= 8'h00;
            overflow   <= 1'b0;
            lcd_on     <= 1'b0;
            lcd_blon   <= 1'b0;
        end else begin
            go_prev  <= in_port[11];
            lcd_on   <= in_port[9];
            lcd_blon <= in_port[10];
            if (go && (!pend_valid || consume)) begin
                pend_valid <= 1'b1;
                pend_rs    <= in_port[8];
                pend_data  <= in_port[7:0];
            end else if (consume) begin
                pend_valid <= 1'b0;
            end
            if (ovf_set)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    // EN comes straight from this register so the LCD never sees a glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            lcd_en   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pend_valid) begin
                        lcd_rs   <= pend_rs;
                        lcd_data <= pend_data;
                        cnt      <= CW'(T_AS - 1);
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        lcd_en <= 1'b1;
                        cnt    <= CW'(T_PW - 1);
                        state  <= S_PULSE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_PULSE: begin
                    if (cnt == '0) begin
                        lcd_en <= 1'b0;
                        cnt    <= CW'(T_H - 1);
                        state  <= S_HOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        cnt   <= wait_load(lcd_rs, lcd_data);
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_WAIT: begin
                    if (cnt == '0)
                        state <= S_IDLE;
                    else
                        cnt <= cnt - CW'(1);
                end
                default: begin
                    state  <= S_IDLE;
                    lcd_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_hd44780_sequencer.sv
// Bench for lcd_hd44780_sequencer: a timeline model of each write cycle checked
// every cycle, plus directed scenarios with hand-computed edge distances.
module tb_lcd_hd44780_sequencer;

    localparam int T_AS    = 3;
    localparam int T_PW    = 12;
    localparam int T_H     = 2;
    localparam int T_SHORT = 2000;
    localparam int T_LONG  = 82000;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] in_port = 12'h000;
    logic        ovf_clr = 1'b0;
    logic        busy, overflow, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon;
    logic [7:0]  lcd_data;

    lcd_hd44780_sequencer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .ovf_clr  (ovf_clr),
        .busy     (busy),
        .overflow (overflow),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en),
        .lcd_on   (lcd_on),
        .lcd_blon (lcd_blon)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int tcyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        tcyc++;
    end

    // Model: each accepted word occupies a fixed window of edges after it is taken.
    int         m_cyc, m_done, m_start;
    bit         m_started, m_gp, m_pv, m_ovf, m_on, m_blon;
    logic [8:0] m_pw, m_cur;

    function automatic int twait(input logic [8:0] w);
        return (!w[8] && w[7:0] >= 8'h01 && w[7:0] <= 8'h03) ? T_LONG : T_SHORT;
    endfunction

    task model_reset();
        m_cyc = 0; m_done = 0; m_start = 0; m_started = 0;
        m_gp = 0; m_pv = 0; m_ovf = 0; m_on = 0; m_blon = 0;
        m_pw = '0; m_cur = '0;
    endtask

    initial forever begin
        bit set_ovf;
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            model_reset();
        end else begin
            m_cyc++;
            set_ovf = 0;
            if (m_pv && (m_cyc - 1 >= m_done)) begin
                m_start   = m_cyc;
                m_started = 1;
                m_cur     = m_pw;
                m_done    = m_cyc + T_AS + T_PW + T_H + twait(m_pw);
                m_pv      = 0;
            end
            if (in_port[11] != m_gp) begin
                m_gp = in_port[11];
                if (!m_pv) begin
                    m_pv = 1;
                    m_pw = in_port[8:0];
                end else begin
                    set_ovf = 1;
                end
            end
            m_ovf  = set_ovf ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
            m_on   = in_port[9];
            m_blon = in_port[10];
        end
    end

    initial forever begin
        logic        e_en, e_busy;
        logic [14:0] exp_v;
        @(negedge clk);
        e_en   = m_started && (m_cyc >= m_start + T_AS) && (m_cyc < m_start + T_AS + T_PW);
        e_busy = m_pv || (m_cyc < m_done);
        exp_v  = {e_busy, m_ovf, e_en, m_cur[8], 1'b0, m_on, m_blon, m_cur[7:0]};
        check("model_outputs", {17'd0, busy, overflow, lcd_en, lcd_rs, lcd_rw, lcd_on, lcd_blon, lcd_data},
              {17'd0, exp_v});
    end

    int  rises[$];
    int  last_fall = 0;
    int  busy_fall = 0;
    logic en_q = 1'b0, busy_q = 1'b0;

    initial forever begin
        @(negedge clk);
        if (lcd_en && !en_q) rises.push_back(tcyc);
        if (!lcd_en && en_q) last_fall = tcyc;
        if (!busy && busy_q) busy_fall = tcyc;
        en_q   = lcd_en;
        busy_q = busy;
    end

    function automatic int rise_at(input int i);
        return (i < rises.size()) ? rises[i] : -1;
    endfunction

    task automatic go(input logic [10:0] w, output int g);
        in_port = {~in_port[11], w};
        g = tcyc + 1;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int g, g1, n0, n;
        repeat (3) @(negedge clk);
        check("reset_outputs", {17'd0, busy, overflow, lcd_en, lcd_rs, lcd_rw, lcd_on, lcd_blon, lcd_data}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Data write 0x41 with RS=1
        go(11'h141, g);
        @(negedge clk);
        check("t1_busy_after_go", {31'd0, busy}, 32'd1);
        check("t1_en_low_early", {31'd0, lcd_en}, 32'd0);
        @(negedge clk);
        check("t1_rs_data", {23'd0, lcd_rs, lcd_data}, 32'h141);
        wait_idle("t1_busy_timeout", 2100);
        check("t1_rise_delay", rise_at(0) - g, 4);
        check("t1_en_width", last_fall - rise_at(0), 12);
        check("t1_busy_len", busy_fall - g, 2018);
        check("t1_pulse_count", rises.size(), 1);

        // Clear display takes the long wait
        @(negedge clk);
        go(11'h001, g);
        repeat (2) @(negedge clk);
        check("t2_rs_data", {23'd0, lcd_rs, lcd_data}, 32'h001);
        wait_idle("t2_busy_timeout", 83000);
        check("t2_busy_len", busy_fall - g, 82018);

        // Back-to-back words, then drops during WAIT
        @(negedge clk);
        n0 = rises.size();
        go(11'h130, g1);
        repeat (5) @(negedge clk);
        go(11'h131, g);
        @(negedge clk);
        check("t3_no_ovf_queued", {31'd0, overflow}, 32'd0);
        repeat (100) @(negedge clk);
        check("t3_no_ovf_wait", {31'd0, overflow}, 32'd0);
        go(11'h132, g);
        @(negedge clk);
        check("t4_ovf_on_drop", {31'd0, overflow}, 32'd1);
        repeat (3) @(negedge clk);
        go(11'h133, g);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("t4_set_beats_clear", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("t4_clear", {31'd0, overflow}, 32'd0);
        wait_idle("t3_busy_timeout", 4200);
        check("t3_pulse_count", rises.size() - n0, 2);
        check("t3_first_rise", rise_at(n0) - g1, 4);
        check("t3_rise_spacing", rise_at(n0 + 1) - rise_at(n0), 2018);
        check("t4_last_data", {23'd0, lcd_rs, lcd_data}, 32'h131);

        // Reset in the middle of the EN pulse
        @(negedge clk);
        go(11'h141, g);
        n = 0;
        while (!lcd_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_in_pulse", {31'd0, lcd_en}, 32'd1);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t5_async_en", {31'd0, lcd_en}, 32'd0);
        check("t5_async_outputs", {17'd0, busy, overflow, lcd_en, lcd_rs, lcd_rw, lcd_on, lcd_blon, lcd_data}, 32'd0);
        in_port = 12'h000;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        n0 = rises.size();
        repeat (40) @(negedge clk);
        check("t5_no_pulse_after", rises.size(), n0);
        check("t5_idle_after", {31'd0, busy}, 32'd0);

        // Backlight and power bits without a toggle
        in_port = 12'h600;
        #1;
        check("t6_on_before", {30'd0, lcd_on, lcd_blon}, 32'd0);
        @(posedge clk);
        #1;
        check("t6_on_after", {30'd0, lcd_on, lcd_blon}, 32'd3);
        repeat (20) @(negedge clk);
        check("t6_no_busy", {31'd0, busy}, 32'd0);
        check("t6_no_pulse", rises.size(), n0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
